// File: rtl/hyperbus_ctrl.sv
// HyperBus transaction controller: turns single-burst native read/write requests into
// CA / initial-latency / data phases on a 16-bit-per-cycle DDR PHY abstraction.
module hyperbus_ctrl #(
   parameter int HBUS_ADDR_WIDTH = 32,
   parameter int HBUS_DATA_WIDTH = 16,
   parameter int BURST_WORDS     = 2,
   parameter int LATENCY         = 6,
   parameter int TCSH            = 2,
   parameter int TIMEOUT         = 64
) (
   input  logic                       hbus_clk,
   input  logic                       hbus_rst,
   input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
   input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
   output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
   input  logic                       hbus_rrq,
   input  logic                       hbus_wrq,
   output logic                       hbus_ready,
   output logic                       hbus_valid,
   output logic                       hbus_busy,
   output logic                       hbus_err,
   output logic                       hb_cs_n,
   output logic                       hb_ck_en,
   output logic [15:0]                hb_dq_o,
   output logic                       hb_dq_oe,
   input  logic [15:0]                hb_dq_i,
   output logic [1:0]                 hb_rwds_o,
   output logic                       hb_rwds_oe,
   input  logic [1:0]                 hb_rwds_i,
   output logic [2:0]                 fsm_state
);

   // Handshake: hbus_ready=1 means hbus_dat_i is consumed at the closing edge of that cycle;
   // hbus_valid=1 means hbus_dat_o holds a read word for that cycle only. Neither can be stalled.

   typedef enum logic [2:0] {IDLE, CA, LAT, XFER, CSH} state_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    BW       = 8'(BURST_WORDS);
   localparam logic [7:0]    BW_LAST  = 8'(BURST_WORDS - 1);
   localparam logic [7:0]    LAT_ONE  = 8'(LATENCY);
   localparam logic [7:0]    LAT_DBL  = 8'(2 * LATENCY);
   localparam logic [7:0]    CSH_LAST = 8'(TCSH - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   state_t              state, state_d;
   logic [7:0]          cnt, cnt_d;
   logic [7:0]          wcnt, wcnt_d;
   logic [TW-1:0]       tcnt, tcnt_d;
   logic [7:0]          lat_n, lat_n_d;
   logic                rw_q, rw_d;
   logic [31:0]         ca_lo, ca_lo_d;
   logic                cs_n_d, ck_en_d, dq_oe_d, rwds_oe_d;
   logic                ready_d, valid_d, busy_d, err_d;
   logic [15:0]         dq_o_d;
   logic [1:0]          rwds_o_d;
   logic [HBUS_DATA_WIDTH-1:0] dat_o_d;
   logic [47:0]         ca_full;
   logic                strobe;

   function automatic logic [47:0] build_ca(input logic rw, input logic [31:0] adr);
      return {rw, 1'b0, 1'b1, adr[31:3], 13'd0, adr[2:0]};
   endfunction

   assign ca_full   = build_ca(hbus_rrq, hbus_adr_i);
   assign strobe    = (hb_rwds_i == 2'b10);
   assign fsm_state = state;

   always_ff @(posedge hbus_clk or posedge hbus_rst) begin
      if (hbus_rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         wcnt       <= 8'd0;
         tcnt       <= '0;
         lat_n      <= LAT_ONE;
         rw_q       <= 1'b0;
         ca_lo      <= 32'd0;
         hb_cs_n    <= 1'b1;
         hb_ck_en   <= 1'b0;
         hb_dq_o    <= 16'd0;
         hb_dq_oe   <= 1'b0;
         hb_rwds_o  <= 2'b00;
         hb_rwds_oe <= 1'b0;
         hbus_ready <= 1'b0;
         hbus_valid <= 1'b0;
         hbus_busy  <= 1'b0;
         hbus_err   <= 1'b0;
         hbus_dat_o <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         wcnt       <= wcnt_d;
         tcnt       <= tcnt_d;
         lat_n      <= lat_n_d;
         rw_q       <= rw_d;
         ca_lo      <= ca_lo_d;
         hb_cs_n    <= cs_n_d;
         hb_ck_en   <= ck_en_d;
         hb_dq_o    <= dq_o_d;
         hb_dq_oe   <= dq_oe_d;
         hb_rwds_o  <= rwds_o_d;
         hb_rwds_oe <= rwds_oe_d;
         hbus_ready <= ready_d;
         hbus_valid <= valid_d;
         hbus_busy  <= busy_d;
         hbus_err   <= err_d;
         hbus_dat_o <= dat_o_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (hbus_rrq || hbus_wrq) state_d = CA;
         CA:   if (cnt == 8'd2) state_d = LAT;
         LAT:  if (cnt == lat_n - 8'd1) state_d = XFER;
         XFER: begin
            if (rw_q) begin
               if (strobe && wcnt == BW_LAST) state_d = CSH;
               else if (!strobe && tcnt == TO_LAST) state_d = CSH;
            end else if (wcnt == BW) begin
               state_d = CSH;
            end
         end
         CSH:  if (cnt == CSH_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = (state_d == state) ? cnt + 8'd1 : 8'd0;
      wcnt_d    = 8'd0;
      tcnt_d    = '0;
      lat_n_d   = lat_n;
      rw_d      = rw_q;
      ca_lo_d   = ca_lo;
      cs_n_d    = 1'b1;
      ck_en_d   = 1'b0;
      busy_d    = (state_d != IDLE);
      dq_o_d    = hb_dq_o;
      dq_oe_d   = 1'b0;
      rwds_o_d  = 2'b00;
      rwds_oe_d = 1'b0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      dat_o_d   = hbus_dat_o;
      if (state_d inside {CA, LAT, XFER}) begin
         cs_n_d  = 1'b0;
         ck_en_d = 1'b1;
      end
      case (state)
         IDLE: begin
            if (state_d == CA) begin
               rw_d    = hbus_rrq;
               ca_lo_d = ca_full[31:0];
               dq_o_d  = ca_full[47:32];
            end
         end
         CA: begin
            dq_o_d = (cnt == 8'd0) ? ca_lo[31:16] : ca_lo[15:0];
            // Only the last CA cycle's RWDS decides whether the device wants double latency.
            if (cnt == 8'd2) lat_n_d = hb_rwds_i[1] ? LAT_DBL : LAT_ONE;
         end
         XFER: begin
            if (rw_q) begin
               wcnt_d  = wcnt + {7'd0, strobe};
               tcnt_d  = strobe ? '0 : tcnt + TW'(1);
               valid_d = strobe;
               err_d   = !strobe && (tcnt == TO_LAST);
               if (strobe) dat_o_d = hb_dq_i;
            end else begin
               wcnt_d    = wcnt + {7'd0, hbus_ready};
               dq_oe_d   = (state_d == XFER) && (hb_dq_oe || hbus_ready);
               rwds_oe_d = dq_oe_d;
               if (hbus_ready) dq_o_d = hbus_dat_i;
            end
         end
         default: ;
      endcase
      if (state_d == CA) dq_oe_d = 1'b1;
      ready_d = (state_d == XFER) && !rw_d && (wcnt_d < BW);
   end

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Bench for hyperbus_ctrl: a phase-level model plans per-cycle inputs and expected outputs;
// one negedge process compares the DUT against that plan.
module tb_hyperbus_ctrl;

   localparam int LATENCY = 6;
   localparam int TIMEOUT = 64;
   localparam int BURST   = 2;
   localparam int TCSH    = 2;

   // expected control vector: {cs_n, ck_en, busy, dq_oe, rwds_oe, ready, valid, err}
   localparam logic [7:0] C_IDLE = 8'b1000_0000;
   localparam logic [7:0] C_CA   = 8'b0111_0000;
   localparam logic [7:0] C_LAT  = 8'b0110_0000;

   logic        hbus_clk = 1'b0;
   logic        hbus_rst = 1'b1;
   logic [31:0] hbus_adr_i = 32'd0;
   logic [15:0] hbus_dat_i = 16'd0;
   logic [15:0] hbus_dat_o;
   logic        hbus_rrq = 1'b0;
   logic        hbus_wrq = 1'b0;
   logic        hbus_ready, hbus_valid, hbus_busy, hbus_err;
   logic        hb_cs_n, hb_ck_en, hb_dq_oe, hb_rwds_oe;
   logic [15:0] hb_dq_o;
   logic [15:0] hb_dq_i = 16'd0;
   logic [1:0]  hb_rwds_o;
   logic [1:0]  hb_rwds_i = 2'b00;
   logic [2:0]  fsm_state;

   int total = 0;
   int bad   = 0;
   int valid_seen = 0;
   int err_seen   = 0;
   int v0, e0;

   logic [39:0] exp_q[$];  // {ctrl[7:0], dq_o[15:0], dat_o[15:0]}
   logic [35:0] drv_q[$];  // {rrq, wrq, rwds[1:0], dq_i[15:0], dat_i[15:0]}
   logic [39:0] cur;

   hyperbus_ctrl dut (
      .hbus_clk   (hbus_clk),
      .hbus_rst   (hbus_rst),
      .hbus_adr_i (hbus_adr_i),
      .hbus_dat_i (hbus_dat_i),
      .hbus_dat_o (hbus_dat_o),
      .hbus_rrq   (hbus_rrq),
      .hbus_wrq   (hbus_wrq),
      .hbus_ready (hbus_ready),
      .hbus_valid (hbus_valid),
      .hbus_busy  (hbus_busy),
      .hbus_err   (hbus_err),
      .hb_cs_n    (hb_cs_n),
      .hb_ck_en   (hb_ck_en),
      .hb_dq_o    (hb_dq_o),
      .hb_dq_oe   (hb_dq_oe),
      .hb_dq_i    (hb_dq_i),
      .hb_rwds_o  (hb_rwds_o),
      .hb_rwds_oe (hb_rwds_oe),
      .hb_rwds_i  (hb_rwds_i),
      .fsm_state  (fsm_state)
   );

   always #5 hbus_clk = ~hbus_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ctrl_now();
      return {hb_cs_n, hb_ck_en, hbus_busy, hb_dq_oe, hb_rwds_oe, hbus_ready, hbus_valid, hbus_err};
   endfunction

   always @(negedge hbus_clk) begin
      if (!hbus_rst) begin
         valid_seen += int'(hbus_valid);
         err_seen   += int'(hbus_err);
      end
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         check("ctrl", {56'd0, ctrl_now()}, {56'd0, cur[39:32]});
         if (cur[36]) check("dq", {46'd0, hb_dq_o, hb_rwds_o}, {46'd0, cur[31:16], 2'b00});
         if (cur[33]) check("dat", {48'd0, hbus_dat_o}, {48'd0, cur[15:0]});
      end
   end

   function automatic logic [15:0] ca_word(input logic rw, input logic [31:0] adr, input int k);
      if (k == 0) return {rw, 2'b01, adr[31:19]};
      if (k == 1) return adr[18:3];
      return {13'd0, adr[2:0]};
   endfunction

   task automatic push_cyc(input logic [7:0] ctl, input logic [15:0] dq, input logic [15:0] dat,
                           input logic rrq, input logic wrq, input logic [1:0] rwds,
                           input logic [15:0] dqi, input logic [15:0] dati);
      exp_q.push_back({ctl, dq, dat});
      drv_q.push_back({rrq, wrq, rwds, dqi, dati});
   endtask

   // Phase-level plan: request cycle, 3 CA words, N latency cycles, data phase, CS# high, idle.
   task automatic plan(input logic rw, input logic both, input logic [31:0] adr, input logic lat_hi,
                       input logic [127:0] stb, input logic [15:0] d0, input logic [15:0] d1);
      logic [15:0] w[2];
      logic [15:0] vd, dqi;
      logic [1:0]  rin;
      logic        v, ab, s, done;
      int          n, got, idle, j;
      w[0] = d0;
      w[1] = d1;
      v = 1'b0; ab = 1'b0; vd = 16'd0;
      push_cyc(C_IDLE, 16'd0, 16'd0, rw, !rw || both, 2'b00, 16'hD00D, 16'hDEAD);
      for (int k = 0; k < 3; k++)
         push_cyc(C_CA, ca_word(rw, adr, k), 16'd0, 1'b0, 1'b0,
                  (k < 2) ? 2'b10 : (lat_hi ? 2'b10 : 2'b01), 16'hD00D, 16'hDEAD);
      n = lat_hi ? 2 * LATENCY : LATENCY;
      for (int k = 0; k < n; k++)
         push_cyc(C_LAT, 16'd0, 16'd0, 1'b0, 1'b0, 2'b00, 16'hD00D, 16'hDEAD);
      if (!rw) begin
         for (int i = 0; i < BURST; i++)
            push_cyc({3'b011, i > 0, i > 0, 1'b1, 2'b00}, (i > 0) ? w[i-1] : 16'd0, 16'd0,
                     1'b0, 1'b0, 2'b00, 16'hD00D, w[i]);
         push_cyc(8'b0111_1000, w[BURST-1], 16'd0, 1'b0, 1'b0, 2'b00, 16'hD00D, 16'hDEAD);
      end else begin
         got = 0; idle = 0; j = 0; done = 1'b0;
         while (!done) begin
            s   = stb[j];
            rin = s ? 2'b10 : ((j % 3 == 1) ? 2'b00 : ((j % 3 == 2) ? 2'b01 : 2'b11));
            dqi = s ? w[got] : 16'h0F00 + 16'(j);
            push_cyc({3'b011, 3'b000, v, 1'b0}, 16'd0, vd, 1'b0, 1'b0, rin, dqi, 16'hDEAD);
            v = s;
            if (s) begin
               vd = dqi;
               got++;
               idle = 0;
            end else begin
               idle++;
            end
            if (got == BURST) done = 1'b1;
            if (idle == TIMEOUT) begin
               done = 1'b1;
               ab = 1'b1;
            end
            j++;
         end
      end
      // extra strobes during CS# high must be ignored
      for (int k = 0; k < TCSH; k++)
         push_cyc({3'b101, 3'b000, (k == 0) ? v : 1'b0, (k == 0) ? ab : 1'b0}, 16'd0, vd,
                  1'b0, 1'b0, 2'b10, 16'hEEEE, 16'hDEAD);
      push_cyc(C_IDLE, 16'd0, 16'd0, 1'b0, 1'b0, 2'b00, 16'hD00D, 16'hDEAD);
   endtask

   task automatic do_txn(input logic rw, input logic both, input logic [31:0] adr, input logic lat_hi,
                         input logic [127:0] stb, input logic [15:0] d0, input logic [15:0] d1);
      logic [35:0] d;
      @(posedge hbus_clk);
      #1;
      hbus_adr_i = adr;
      plan(rw, both, adr, lat_hi, stb, d0, d1);
      while (drv_q.size() != 0) begin
         d = drv_q.pop_front();
         {hbus_rrq, hbus_wrq, hb_rwds_i, hb_dq_i, hbus_dat_i} = d;
         if (drv_q.size() != 0) begin
            @(posedge hbus_clk);
            #1;
         end
      end
   endtask

   task automatic idle_inputs();
      hbus_rrq = 1'b0; hbus_wrq = 1'b0; hb_rwds_i = 2'b00; hb_dq_i = 16'd0;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge hbus_clk);
      check("rst_ctrl", {56'd0, ctrl_now()}, {56'd0, C_IDLE});
      check("rst_data", {32'd0, hb_dq_o, hbus_dat_o}, 64'd0);
      check("rst_state", {61'd0, fsm_state}, 64'd0);
      @(posedge hbus_clk);
      #1;
      hbus_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge hbus_clk);
         check("idle_stay", {56'd0, ctrl_now()}, {56'd0, C_IDLE});
      end

      // model pins against hand-computed CA words
      check("ca_w10", {16'd0, ca_word(1'b0, 32'h10, 0), ca_word(1'b0, 32'h10, 1), ca_word(1'b0, 32'h10, 2)},
            64'h0000_2000_0002_0000);
      check("ca_r13", {16'd0, ca_word(1'b1, 32'h13, 0), ca_word(1'b1, 32'h13, 1), ca_word(1'b1, 32'h13, 2)},
            64'h0000_A000_0002_0003);

      do_txn(1'b0, 1'b0, 32'h10, 1'b0, 128'd0, 16'h1234, 16'hABCD);

      v0 = valid_seen;
      do_txn(1'b1, 1'b0, 32'h13, 1'b1, 128'b11, 16'h5A5A, 16'hC3C3);
      check("rd_valid_cnt", 64'(valid_seen - v0), 64'd2);

      v0 = valid_seen;
      do_txn(1'b1, 1'b0, 32'h100, 1'b0, 128'b101, 16'h1111, 16'h2222);
      check("gap_valid_cnt", 64'(valid_seen - v0), 64'd2);

      do_txn(1'b0, 1'b0, 32'hFFFF_FFF5, 1'b1, 128'd0, 16'hBEEF, 16'h0042);

      e0 = err_seen;
      v0 = valid_seen;
      do_txn(1'b1, 1'b1, 32'h40, 1'b0, 128'd0, 16'h0000, 16'h0000);
      check("to_err_cnt", 64'(err_seen - e0), 64'd1);
      check("to_valid_cnt", 64'(valid_seen - v0), 64'd0);

      // reset during latency of a write
      @(posedge hbus_clk);
      #1;
      hbus_adr_i = 32'h20;
      hbus_wrq = 1'b1;
      @(posedge hbus_clk);
      #1;
      hbus_wrq = 1'b0;
      repeat (4) @(posedge hbus_clk);
      #3;
      check("lat_in_lat", {56'd0, ctrl_now()}, {56'd0, C_LAT});
      hbus_rst = 1'b1;
      #1;
      check("lat_rst_async", {56'd0, ctrl_now()}, {56'd0, C_IDLE});
      @(negedge hbus_clk);
      check("lat_rst_hold", {56'd0, ctrl_now()}, {56'd0, C_IDLE});
      @(posedge hbus_clk);
      #1;
      hbus_rst = 1'b0;
      @(negedge hbus_clk);
      check("lat_rst_after", {56'd0, ctrl_now()}, {56'd0, C_IDLE});
      do_txn(1'b0, 1'b0, 32'h28, 1'b0, 128'd0, 16'h0F0F, 16'hF0F0);

      // reset during a read data phase while a strobe is on the pins
      @(posedge hbus_clk);
      #1;
      hbus_adr_i = 32'h30;
      hbus_rrq = 1'b1;
      @(posedge hbus_clk);
      #1;
      hbus_rrq = 1'b0;
      repeat (9) @(posedge hbus_clk);
      #1;
      hb_rwds_i = 2'b10;
      hb_dq_i = 16'h7777;
      #2;
      check("xfer_in_xfer", {56'd0, ctrl_now()}, {56'd0, 8'b0110_0000});
      hbus_rst = 1'b1;
      #1;
      check("xfer_rst_async", {56'd0, ctrl_now()}, {56'd0, C_IDLE});
      @(negedge hbus_clk);
      @(negedge hbus_clk);
      check("xfer_rst_novalid", {56'd0, ctrl_now()}, {56'd0, C_IDLE});
      @(posedge hbus_clk);
      #1;
      idle_inputs();
      hbus_rst = 1'b0;
      do_txn(1'b1, 1'b0, 32'h38, 1'b0, 128'b1001, 16'h6161, 16'h9292);

      repeat (3) @(posedge hbus_clk);
      check("plan_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
